// File: rtl/lab4_branch_update_queue_if.sv
// Fetch/execute-facing bundle of the branch update queue: enqueue, resolve, flush,
// predictor training outputs and occupancy.
interface lab4_branch_update_queue_if #(
   parameter int unsigned NUM_ENTRIES = 4
);
   localparam int unsigned PTR_W = $clog2(NUM_ENTRIES);

   logic           enq_val;
   logic           enq_rdy;
   logic [31:0]    enq_pc;
   logic           enq_pred;
   logic           res_val;
   logic           res_rdy;
   logic           res_taken;
   logic           flush;
   logic           update_en;
   logic           update_val;
   logic [31:0]    update_pc;
   logic           mispred;
   logic [PTR_W:0] count;

   modport master (
      output enq_val, enq_pc, enq_pred, res_val, res_taken, flush,
      input  enq_rdy, res_rdy, update_en, update_val, update_pc, mispred, count
   );

   modport slave (
      input  enq_val, enq_pc, enq_pred, res_val, res_taken, flush,
      output enq_rdy, res_rdy, update_en, update_val, update_pc, mispred, count
   );
endinterface

// File: rtl/lab4_branch_update_queue.sv
// In-order queue of predicted branches; trains the bimodal predictor on resolve and
// squashes younger entries on a mispredict or external flush.
module lab4_branch_update_queue #(
   parameter int unsigned NUM_ENTRIES = 4
) (
   input logic                        clk,
   input logic                        reset,
   lab4_branch_update_queue_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(NUM_ENTRIES);

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   cnt_t;

   localparam cnt_t FULL_CNT = cnt_t'(NUM_ENTRIES);

   ptr_t head_q, head_d;
   ptr_t tail_q, tail_d;
   cnt_t count_q, count_d;

   logic [31:0]            pc_mem [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] pred_mem;

   logic        update_en_q, update_val_q, mispred_q;
   logic [31:0] update_pc_q;

   logic        enq_rdy, res_rdy;
   logic        enq_fire, res_fire;
   logic        enq_keep, squash, mispred_d;
   logic [31:0] head_pc;
   logic        head_pred;

   // Readies depend on occupancy only, so a full queue never accepts via a same-cycle resolve.
   assign enq_rdy = (count_q != FULL_CNT);
   assign res_rdy = (count_q != '0);

   assign enq_fire = bus.enq_val && enq_rdy;
   assign res_fire = bus.res_val && res_rdy;

   assign head_pc   = pc_mem[head_q];
   assign head_pred = pred_mem[head_q];

   assign mispred_d = res_fire && (head_pred != bus.res_taken);
   assign squash    = bus.flush || mispred_d;
   // A wrong-path enqueue is accepted by the handshake but never stored.
   assign enq_keep  = enq_fire && !squash;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (res_fire) begin
         head_d = head_q + ptr_t'(1);
      end
      if (enq_keep) begin
         tail_d = tail_q + ptr_t'(1);
      end

      if (squash) begin
         count_d = '0;
         head_d  = tail_d;
      end else if (enq_fire && !res_fire) begin
         count_d = count_q + cnt_t'(1);
      end else if (res_fire && !enq_fire) begin
         count_d = count_q - cnt_t'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq_keep) begin
         pc_mem[tail_q]   <= bus.enq_pc;
         pred_mem[tail_q] <= bus.enq_pred;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         update_en_q  <= 1'b0;
         update_val_q <= 1'b0;
         update_pc_q  <= '0;
         mispred_q    <= 1'b0;
      end else begin
         update_en_q <= res_fire;
         mispred_q   <= mispred_d;
         if (res_fire) begin
            update_val_q <= bus.res_taken;
            update_pc_q  <= head_pc;
         end
      end
   end

   assign bus.enq_rdy    = enq_rdy;
   assign bus.res_rdy    = res_rdy;
   assign bus.update_en  = update_en_q;
   assign bus.update_val = update_val_q;
   assign bus.update_pc  = update_pc_q;
   assign bus.mispred    = mispred_q;
   assign bus.count      = count_q;
endmodule

// File: doc/lab4_branch_update_queue.md
Name: lab4_branch_update_queue

Overview:
- In-order queue of in-flight predicted branches, sitting directly downstream of the bimodal predictor.
- At fetch it captures {PC, prediction} for each predicted branch. At execute it receives the resolved direction of the oldest branch.
- It drives registered update_en/update_val/update_pc back into the predictor's training port.
- It flags mispredictions and squashes all younger entries on a mispredict.

Parameters:
- NUM_ENTRIES, 4, queue depth; power of two, >= 2.
- PTR_W, $clog2(NUM_ENTRIES), pointer width (derived; not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enq_val  in  1  fetch presents a predicted branch.
- enq_rdy  out  1  queue can accept an entry.
- enq_pc  in  32  PC of the branch.
- enq_pred  in  1  predictor output for that PC (1 = taken).
- res_val  in  1  execute presents the resolved outcome of the oldest branch.
- res_rdy  out  1  an entry exists to be resolved.
- res_taken  in  1  actual branch direction.
- flush  in  1  external squash (e.g. exception); clears all entries.
- update_en  out  1  one-cycle pulse: train the predictor.
- update_val  out  1  direction to train with.
- update_pc  out  32  PC to train.
- mispred  out  1  one-cycle pulse: resolved direction != predicted.
- count  out  PTR_W+1  number of valid entries.

Behaviour:
- Storage:
  - Circular buffer of NUM_ENTRIES x {pc[31:0], pred}, with head/tail pointers PTR_W bits wide plus a count register.
  - Pointers wrap modulo NUM_ENTRIES (tail at NUM_ENTRIES-1 wraps to 0).
- Reset (reset == 0, asynchronous):
  - head=0, tail=0, count=0.
  - update_en=0, update_val=0, update_pc=0, mispred=0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately; no update pulse is produced for them.
- Handshakes:
  - enq_rdy = (count != NUM_ENTRIES). Enq fires when enq_val && enq_rdy.
  - res_rdy = (count != 0). Res fires when res_val && res_rdy.
  - No bypass: a full queue does not accept an enq even if a resolve fires in the same cycle. An empty queue does not resolve an enq arriving in the same cycle.
  - Both ready signals are combinational from state only, never from the val inputs.
- Resolve (res fire):
  - Head entry is dequeued.
  - On the next rising edge: update_en=1, update_val=res_taken, update_pc=head.pc, mispred=(head.pred != res_taken).
  - Latency is exactly 1 cycle from res fire to update pulse.
  - In any cycle without a res fire, update_en=0 and mispred=0; update_pc/update_val hold their last values.
- Mispredict squash:
  - If res fires with head.pred != res_taken, every entry younger than head is discarded: next count=0, next head=next tail.
  - An enq firing in the same cycle is also discarded (wrong path). enq_rdy is not lowered for it.
- Flush:
  - Next count=0, head=tail.
  - Overrides any simultaneous enq.
  - A simultaneous res fire is still honoured: the update pulse is produced for the head entry, then everything is cleared.
- Simultaneous enq + correct resolve (count unchanged):
  - Head advances, tail advances, count stays.
  - Entries are written and read in distinct slots. When count==1 with head==tail-1, the resolve reads the old slot and the new entry occupies the next slot.
- count update rule, in priority order:
  1. flush or mispredict -> 0.
  2. Otherwise +1 on enq only, -1 on res only, unchanged on both or neither.

Test Plan:
- Reset, then enq pc=0x100 pred=1, then res_taken=1 -> one cycle later update_en=1, update_pc=0x100, update_val=1, mispred=0; count returns to 0.
- Enq 4 entries (pc 0x200,0x204,0x208,0x20C) -> enq_rdy=0 with count=4; fifth enq is held. Resolve one with the correct direction -> enq_rdy=1; a fifth enq at 0x210 then wraps tail to slot 0.
- Enq 0x300 pred=0, 0x304, 0x308; resolve res_taken=1 -> mispred=1, update_pc=0x300, update_val=1; count=0; res_rdy=0 next cycle.
- With count=2, same-cycle enq 0x400 and correct resolve -> count stays 2, update_pc = old head. Repeat 8 cycles to exercise pointer wrap with in-order PCs.
- flush with count=3 while res fires on head 0x500 -> update pulse for 0x500 only, count=0; a simultaneous enq is dropped.
- Assert reset low mid-stream with count=3 -> outputs 0 asynchronously, count=0; after release, an enq/res pair behaves as in the first scenario.
